// File: rtl/wrr_sched_pkg.sv
// Shared types and helpers for the weighted round-robin burst scheduler.
// State encoding, default sizes and the one-hot to index encoder.
package wrr_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ   = 8;
  localparam int DEF_CREDIT_W  = 4;
  localparam int DEF_TIMEOUT_W = 6;

  // OR-reduction encoder; valid for one-hot or all-zero input up to 16 bits.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_burst_scheduler_pick.sv
// Rotating-priority pick as log2(N) circular parallel-prefix layers.
// The prefix chain is cut at the one-hot priority position.
module rr_prefix_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_prio,
  output logic [N-1:0] o_gnt,
  output logic         o_any
);

  localparam int L = $clog2(N);

  // w_v[k][i]: any request in the 2^k positions ending at i, stopping at prio.
  logic [N-1:0] w_v [0:L];
  logic [N-1:0] w_s [0:L-1];

  assign w_v[0] = i_req;
  assign w_s[0] = i_prio;

  for (genvar k = 0; k < L; k++) begin : g_layer
    localparam int D = 1 << k;
    for (genvar i = 0; i < N; i++) begin : g_bit
      localparam int J = (i + N - D) % N;
      assign w_v[k+1][i] = w_v[k][i] | (~w_s[k][i] & w_v[k][J]);
      if (k < L - 1) begin : g_stop
        assign w_s[k+1][i] = w_s[k][i] | w_s[k][J];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_gnt
    localparam int P = (i + N - 1) % N;
    assign o_gnt[i] = i_req[i] & (i_prio[i] | ~w_v[L][P]);
  end

  assign o_any = |i_req;

endmodule

// File: rtl/wrr_burst_scheduler.sv
// Packet-atomic weighted round-robin scheduler for one shared beat resource.
// Optional idle-owner watchdog enabled by defining WRR_TIMEOUT_EN.
module wrr_burst_scheduler
  import wrr_sched_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int CREDIT_W  = DEF_CREDIT_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*CREDIT_W-1:0] i_weight,
  input  logic                        i_beat,
  input  logic                        i_last,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic                        o_busy,
  output logic                        o_timeout
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IDW-1:0]      r_grant_id;
  logic [IDW-1:0]      r_ptr;
  logic [CREDIT_W-1:0] r_credit;

  logic [IDW-1:0]      w_pick_ptr;
  logic [IDW-1:0]      w_pick_id;
  logic [NUM_REQ-1:0]  w_prio;
  logic [NUM_REQ-1:0]  w_pick;
  logic                w_any;
  logic [CREDIT_W-1:0] w_weight;
  logic [CREDIT_W-1:0] w_load;
  logic [CREDIT_W-1:0] w_credit_dec;
  logic                w_beat_own;
  logic                w_rel_pkt;
  logic                w_rel_to;
  logic                w_release;
  logic                w_load_en;

  // On release the owner's successor gets top priority in the same cycle.
  assign w_pick_ptr = (r_state == OWN) ? IDW'(r_grant_id + 1'b1) : r_ptr;
  assign w_prio     = NUM_REQ'(1) << w_pick_ptr;

  rr_prefix_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .i_req  (i_req),
    .i_prio (w_prio),
    .o_gnt  (w_pick),
    .o_any  (w_any)
  );

  assign w_pick_id = IDW'(onehot_to_idx(16'(w_pick)));
  assign w_weight  = i_weight[w_pick_id*CREDIT_W +: CREDIT_W];
  assign w_load    = (w_weight == '0) ? CREDIT_W'(1) : w_weight;

  assign w_beat_own   = i_beat & (r_state == OWN);
  assign w_credit_dec = (w_beat_own && r_credit != '0) ?
                        r_credit - 1'b1 : r_credit;
  assign w_rel_pkt    = w_beat_own & i_last &
                        ((w_credit_dec == '0) | ~i_req[r_grant_id]);

`ifdef WRR_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wdog;
  logic                 r_timeout;

  assign w_rel_to = (r_state == OWN) & ~i_beat & (&r_wdog);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_rel_to;
      if (i_beat || w_release || r_state != OWN) r_wdog <= '0;
      else r_wdog <= r_wdog + 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic [TIMEOUT_W-1:0] w_unused_wdog;

  assign w_unused_wdog = '0;
  assign w_rel_to      = 1'b0;
  assign o_timeout     = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_credit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_release) r_ptr <= w_pick_ptr;
      if (w_load_en) begin
        r_grant    <= w_pick;
        r_grant_id <= w_pick_id;
        r_credit   <= w_load;
      end else if (w_release) begin
        r_grant    <= '0;
        r_grant_id <= '0;
        r_credit   <= '0;
      end else begin
        r_credit <= w_credit_dec;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    w_load_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = OWN;
          w_load_en   = 1'b1;
        end
      end
      OWN: begin
        w_release = w_rel_pkt | w_rel_to;
        if (w_release) begin
          w_load_en   = w_any;
          w_state_nxt = w_any ? OWN : IDLE;
        end
      end
    endcase
  end

  always_comb begin
    o_busy     = (r_state == OWN);
    o_grant    = r_grant;
    o_grant_id = r_grant_id;
  end

endmodule
